// File: rtl/scarf_pkg.sv
// Shared types and constants for the SCARF SPI front end.
//   scarf_spi_state_t : transaction state (IDLE, HEADER, DATA)
//   RNW_BIT           : position of the read-not-write flag in the header byte
//   SLAVE_ID_W        : width of the slave id carried in the header byte
package scarf_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, DATA} scarf_spi_state_t;
  localparam int RNW_BIT    = 7;
  localparam int SLAVE_ID_W = 7;
endpackage

// File: rtl/scarf_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
// Ports:
//   clk      in  system clock
//   rst_sync in  synchronous active-high reset, loads RST_VAL into every stage
//   d        in  asynchronous input
//   q        out synchronized output, STAGES clocks of latency
module scarf_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_sync,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_sr;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sync_sr <= {STAGES{RST_VAL}};
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
    end
  end

  assign q = sync_sr[STAGES-1];
endmodule

// File: rtl/scarf_spi_slave.sv
// SPI (mode 0) slave front end of the SCARF register/BRAM bus.
// Oversamples sclk/mosi/cs_n in the clk domain, decodes the header byte
// {rnw, slave_id} and presents every following byte to the downstream slaves.
// The OR-combined read data of the slaves is shifted back out on miso.
// Ports:
//   clk              in  system clock, at least 8x the sclk frequency
//   rst_sync         in  synchronous active-high reset
//   sclk, mosi, cs_n in  SPI pins, asynchronous to clk
//   miso             out SPI data out, MSB first
//   read_data_in     in  OR of all slaves' read data
//   data_in          out last completed data byte (header excluded)
//   data_in_valid    out one-clk pulse per completed data byte
//   data_in_finished out one-clk pulse at the end of a transaction
//   slave_id, rnw    out decoded header, zero while idle
module scarf_spi_slave
  import scarf_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  input  logic [7:0] read_data_in,
  output logic [7:0] data_in,
  output logic       data_in_valid,
  output logic       data_in_finished,
  output logic [6:0] slave_id,
  output logic       rnw
);
  logic sclk_p0, mosi_p0, cs_n_p0, flushed_p0;
  logic sclk_p1, cs_n_p1;
  logic sclk_rise, sclk_fall, cs_rise;

  scarf_spi_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;
  logic       armed;
  logic       load_pend;
  logic       fin_pend;
  logic [7:0] rx_byte;
  logic       byte_done;

  // Stage p0: pin synchronizers
  scarf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_sync(rst_sync), .d(sclk), .q(sclk_p0)
  );
  scarf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_sync(rst_sync), .d(mosi), .q(mosi_p0)
  );
  scarf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_sync(rst_sync), .d(cs_n), .q(cs_n_p0)
  );
  // The cs_n chain still holds its reset value (high) for SYNC_STAGES clocks
  // after reset. This twin chain goes high exactly when the real pin value
  // reaches cs_n_p0, so a reset taken with cs_n low cannot arm the slave.
  scarf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_flush (
    .clk(clk), .rst_sync(rst_sync), .d(1'b1), .q(flushed_p0)
  );

  // Stage p1: edge detection against a one-clk delayed copy
  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign cs_rise   = cs_n_p0 & ~cs_n_p1;

  assign rx_byte   = {rx_sr, mosi_p0};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed && !cs_n_p0) state_d = HEADER;
      HEADER:  if (byte_done) state_d = DATA;
      DATA:    state_d = DATA;
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // Stage p2: FSM, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sclk_p1          <= 1'b0;
      cs_n_p1          <= 1'b1;
      state_q          <= IDLE;
      bit_cnt          <= 3'd0;
      rx_sr            <= '0;
      tx_sr            <= '0;
      armed            <= 1'b0;
      load_pend        <= 1'b0;
      fin_pend         <= 1'b0;
      miso             <= 1'b0;
      data_in          <= '0;
      data_in_valid    <= 1'b0;
      data_in_finished <= 1'b0;
      slave_id         <= '0;
      rnw              <= 1'b0;
    end else begin
      sclk_p1          <= sclk_p0;
      cs_n_p1          <= cs_n_p0;
      state_q          <= state_d;
      data_in_valid    <= 1'b0;
      data_in_finished <= fin_pend;
      fin_pend         <= 1'b0;

      if (cs_n_p0 && flushed_p0) armed <= 1'b1;

      if (state_q == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        load_pend <= 1'b1;
        if (state_q == HEADER) begin
          slave_id <= rx_byte[SLAVE_ID_W-1:0];
          rnw      <= rx_byte[RNW_BIT];
        end else begin
          data_in       <= rx_byte;
          data_in_valid <= 1'b1;
        end
      end

      // The first falling edge after a byte boundary loads the next return
      // byte; the remaining falls of that byte shift it out.
      if (state_q == DATA) begin
        if (sclk_fall) begin
          if (load_pend) begin
            miso      <= read_data_in[7];
            tx_sr     <= read_data_in[6:0];
            load_pend <= 1'b0;
          end else begin
            miso  <= tx_sr[6];
            tx_sr <= {tx_sr[5:0], 1'b0};
          end
        end
      end else begin
        miso <= 1'b0;
      end

      if (cs_rise) begin
        bit_cnt   <= 3'd0;
        slave_id  <= '0;
        rnw       <= 1'b0;
        load_pend <= 1'b0;
        miso      <= 1'b0;
        // A byte finishing in the same clk as cs_n rising keeps its valid;
        // the finished pulse is pushed one clk later so it never leads it.
        if (byte_done && state_q == DATA) begin
          fin_pend <= 1'b1;
        end else begin
          data_in_finished <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scarf_spi_slave.sv
`timescale 1ns/1ps
module tb_scarf_spi_slave;
  logic       clk = 1'b0;
  logic       rst_sync, sclk, mosi, cs_n, miso;
  logic [7:0] read_data_in, data_in;
  logic       data_in_valid, data_in_finished, rnw;
  logic [6:0] slave_id;

  always #5 clk = ~clk;

  scarf_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_sync(rst_sync), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .read_data_in(read_data_in), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_finished(data_in_finished),
    .slave_id(slave_id), .rnw(rnw)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  int         fin_cnt = 0;
  longint     cyc = 0;
  longint     last_vld_cyc = 0;
  longint     fin_cyc = 0;
  logic [7:0] tx_bytes[0:31];
  logic [7:0] rx_miso[0:31];
  logic [7:0] mem[0:31];
  int         rd_idx = 0;
  logic [6:0] obs_sid;
  logic       obs_rnw;

  // Downstream slave model: echoes slave_id during the first data byte, then
  // returns mem[0], mem[1], ... advancing on every accepted data byte.
  always @(posedge clk) begin
    if (rst_sync || data_in_finished) rd_idx <= 0;
    else if (data_in_valid) rd_idx <= rd_idx + 1;
  end
  assign read_data_in = (rd_idx == 0) ? {1'b0, slave_id} : mem[(rd_idx - 1) & 31];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (data_in_valid) begin
      got_q.push_back(data_in);
      last_vld_cyc <= cyc;
    end
    if (data_in_finished) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc <= cyc;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input int half);
    mosi = b;
    #(half);
    sclk = 1'b1;
    #(half);
    sclk = 1'b0;
  endtask

  // Master transaction: tx_bytes[0..len-1]; optional abort before bit ab_bits
  // of byte ab_byte; simul raises cs_n together with the final sclk rise.
  task automatic xfer(input int len, input int half, input int ab_byte,
                      input int ab_bits, input bit simul, input int gap);
    logic [7:0] cur;
    bit stop;
    stop = 1'b0;
    @(posedge clk); #2;
    cs_n = 1'b0;
    for (int b = 0; b < len && !stop; b++) begin
      cur = tx_bytes[b];
      for (int i = 7; i >= 0; i--) begin
        if (b == ab_byte && (7 - i) == ab_bits) begin
          stop = 1'b1;
          break;
        end
        mosi = cur[i];
        #(half);
        rx_miso[b][i] = miso;
        sclk = 1'b1;
        if (simul && b == len - 1 && i == 0) begin
          obs_sid = slave_id;
          obs_rnw = rnw;
          cs_n    = 1'b1;
        end
        #(half);
        sclk = 1'b0;
      end
    end
    if (!simul) begin
      obs_sid = slave_id;
      obs_rnw = rnw;
      #(half);
      cs_n = 1'b1;
    end
    mosi = 1'b0;
    #(gap);
  endtask

  task automatic wait_fin(input int target);
    for (int k = 0; k < 60; k++) begin
      if (fin_cnt >= target) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_sync = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({miso, data_in, data_in_valid, data_in_finished, slave_id, rnw} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {miso, data_in, data_in_valid, data_in_finished, slave_id, rnw});
    end
    @(posedge clk); #2;
    rst_sync = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_write;
    logic [7:0] exp_b[3] = '{8'h12, 8'h34, 8'hAB};
    logic [7:0] o;
    int f0;
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h12; tx_bytes[2] = 8'h34; tx_bytes[3] = 8'hAB;
    got_q.delete(); f0 = fin_cnt;
    xfer(4, 50, -1, 0, 1'b0, 60);
    wait_fin(f0 + 1);
    n_cmp++; if (obs_sid !== 7'h02) begin n_err++; $display("FAIL write_sid: got %h required 02", obs_sid); end
    n_cmp++; if (obs_rnw !== 1'b0) begin n_err++; $display("FAIL write_rnw: got %b required 0", obs_rnw); end
    n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL write_count: got %0d required 3", got_q.size()); end
    for (int j = 0; j < 3; j++) begin
      o = (j < got_q.size()) ? got_q[j] : 8'hxx;
      n_cmp++; if (o !== exp_b[j]) begin n_err++; $display("FAIL write_byte%0d: got %h required %h", j, o, exp_b[j]); end
    end
    n_cmp++; if (fin_cnt - f0 != 1) begin n_err++; $display("FAIL write_finished: got %0d required 1", fin_cnt - f0); end
    n_cmp++; if (slave_id !== 7'h00) begin n_err++; $display("FAIL write_sid_idle: got %h required 00", slave_id); end
    n_cmp++; if (fin_cyc <= last_vld_cyc) begin n_err++; $display("FAIL write_fin_order: got fin %0d valid %0d required fin later", fin_cyc, last_vld_cyc); end
  endtask

  task automatic test_read;
    logic [7:0] exp_m[4] = '{8'h00, 8'h02, 8'h5A, 8'hC3};
    int f0;
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h00;
    tx_bytes[0] = 8'h82; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h3C;
    got_q.delete(); f0 = fin_cnt;
    xfer(4, 50, -1, 0, 1'b0, 60);
    wait_fin(f0 + 1);
    n_cmp++; if (obs_rnw !== 1'b1) begin n_err++; $display("FAIL read_rnw: got %b required 1", obs_rnw); end
    n_cmp++; if (obs_sid !== 7'h02) begin n_err++; $display("FAIL read_sid: got %h required 02", obs_sid); end
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (rx_miso[j] !== exp_m[j]) begin n_err++; $display("FAIL read_miso%0d: got %h required %h", j, rx_miso[j], exp_m[j]); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] o;
    int f0;
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22;
    got_q.delete(); f0 = fin_cnt;
    xfer(3, 50, 2, 5, 1'b0, 60);
    wait_fin(f0 + 1);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL abort_count: got %0d required 1", got_q.size()); end
    o = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++; if (o !== 8'h11) begin n_err++; $display("FAIL abort_byte: got %h required 11", o); end
    n_cmp++; if (fin_cnt - f0 != 1) begin n_err++; $display("FAIL abort_finished: got %0d required 1", fin_cnt - f0); end
    tx_bytes[0] = 8'h05; tx_bytes[1] = 8'h66;
    got_q.delete(); f0 = fin_cnt;
    xfer(2, 50, -1, 0, 1'b0, 60);
    wait_fin(f0 + 1);
    o = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++; if (got_q.size() != 1 || o !== 8'h66) begin n_err++; $display("FAIL abort_next: got %0d bytes first %h required 1 byte 66", got_q.size(), o); end
    n_cmp++; if (obs_sid !== 7'h05) begin n_err++; $display("FAIL abort_next_sid: got %h required 05", obs_sid); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] hdr = 8'h02;
    logic [7:0] b1 = 8'h12;
    logic [7:0] b2 = 8'h34;
    logic [7:0] o;
    int f0;
    got_q.delete();
    @(posedge clk); #2;
    cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(hdr[i], 50);
    for (int i = 7; i >= 4; i--) send_bit(b1[i], 50);
    @(posedge clk); #2;
    rst_sync = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({miso, data_in, data_in_valid, data_in_finished, slave_id, rnw} !== 19'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h required 0",
               {miso, data_in, data_in_valid, data_in_finished, slave_id, rnw});
    end
    @(posedge clk); #2;
    rst_sync = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(b1[i], 50);
    for (int i = 7; i >= 0; i--) send_bit(b2[i], 50);
    n_cmp++; if (slave_id !== 7'h00) begin n_err++; $display("FAIL rstmid_sid: got %h required 00", slave_id); end
    #50; cs_n = 1'b1; #100;
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_novalid: got %0d required 0", got_q.size()); end
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h9C;
    got_q.delete(); f0 = fin_cnt;
    xfer(2, 50, -1, 0, 1'b0, 60);
    wait_fin(f0 + 1);
    o = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++; if (got_q.size() != 1 || o !== 8'h9C) begin n_err++; $display("FAIL rstmid_next: got %0d bytes first %h required 1 byte 9c", got_q.size(), o); end
    n_cmp++; if (obs_sid !== 7'h02) begin n_err++; $display("FAIL rstmid_next_sid: got %h required 02", obs_sid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[5] = '{8'h01, 8'h02, 8'h0F, 8'hF0, 8'h55};
    logic [7:0] o;
    int f0;
    got_q.delete(); f0 = fin_cnt;
    tx_bytes[0] = 8'h03; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h02;
    xfer(3, 40, -1, 0, 1'b0, 40);
    tx_bytes[0] = 8'h04; tx_bytes[1] = 8'h0F; tx_bytes[2] = 8'hF0; tx_bytes[3] = 8'h55;
    xfer(4, 40, -1, 0, 1'b0, 40);
    wait_fin(f0 + 2);
    n_cmp++; if (fin_cnt - f0 != 2) begin n_err++; $display("FAIL b2b_finished: got %0d required 2", fin_cnt - f0); end
    n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL b2b_count: got %0d required 5", got_q.size()); end
    for (int j = 0; j < 5; j++) begin
      o = (j < got_q.size()) ? got_q[j] : 8'hxx;
      n_cmp++; if (o !== exp_b[j]) begin n_err++; $display("FAIL b2b_byte%0d: got %h required %h", j, o, exp_b[j]); end
    end
    n_cmp++; if (obs_sid !== 7'h04) begin n_err++; $display("FAIL b2b_sid: got %h required 04", obs_sid); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] o;
    int f0;
    tx_bytes[0] = 8'h06; tx_bytes[1] = 8'h77; tx_bytes[2] = 8'h88;
    got_q.delete(); f0 = fin_cnt;
    xfer(3, 50, -1, 0, 1'b1, 80);
    wait_fin(f0 + 1);
    o = (got_q.size() > 1) ? got_q[1] : 8'hxx;
    n_cmp++; if (got_q.size() != 2 || o !== 8'h88) begin n_err++; $display("FAIL simul_last: got %0d bytes last %h required 2 bytes last 88", got_q.size(), o); end
    n_cmp++; if (fin_cnt - f0 != 1) begin n_err++; $display("FAIL simul_finished: got %0d required 1", fin_cnt - f0); end
    n_cmp++; if (fin_cyc <= last_vld_cyc) begin n_err++; $display("FAIL simul_order: got fin %0d valid %0d required fin later", fin_cyc, last_vld_cyc); end
  endtask

  task automatic test_random;
    int len, gap, f0;
    logic [7:0] o, em;
    for (int t = 0; t < 100; t++) begin
      len = $urandom_range(1, 16);
      gap = 10 * $urandom_range(4, 9);
      for (int b = 0; b < 16; b++) begin
        tx_bytes[b] = 8'($urandom);
        mem[b]      = 8'($urandom);
      end
      got_q.delete(); f0 = fin_cnt;
      xfer(len, 40, -1, 0, 1'b0, gap);
      wait_fin(f0 + 1);
      n_cmp++; if (fin_cnt - f0 != 1) begin n_err++; $display("FAIL rnd%0d_finished: got %0d required 1", t, fin_cnt - f0); end
      n_cmp++; if (got_q.size() != len - 1) begin n_err++; $display("FAIL rnd%0d_count: got %0d required %0d", t, got_q.size(), len - 1); end
      n_cmp++; if ({obs_rnw, obs_sid} !== tx_bytes[0]) begin n_err++; $display("FAIL rnd%0d_header: got %h required %h", t, {obs_rnw, obs_sid}, tx_bytes[0]); end
      for (int j = 1; j < len; j++) begin
        o = (j - 1 < got_q.size()) ? got_q[j-1] : 8'hxx;
        n_cmp++; if (o !== tx_bytes[j]) begin n_err++; $display("FAIL rnd%0d_byte%0d: got %h required %h", t, j, o, tx_bytes[j]); end
      end
      for (int j = 0; j < len; j++) begin
        em = (j == 0) ? 8'h00 : (j == 1) ? {1'b0, tx_bytes[0][6:0]} : mem[j-2];
        n_cmp++; if (rx_miso[j] !== em) begin n_err++; $display("FAIL rnd%0d_miso%0d: got %h required %h", t, j, rx_miso[j], em); end
      end
      if (len > 1) begin
        n_cmp++; if (fin_cyc <= last_vld_cyc) begin n_err++; $display("FAIL rnd%0d_order: got fin %0d valid %0d required fin later", t, fin_cyc, last_vld_cyc); end
      end
    end
  endtask

  initial begin
    rst_sync = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    test_reset;
    test_write;
    test_read;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_simultaneous;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
